calendar_counter: RTL and testbench
===================================

Name: calendar_counter

Overview:
- Timekeeping core of the millennium clock; runs directly upstream of the display decoding stage.
- Divides the system clock into a 1 s tick and advances a binary sec/min/hour/day/month/year register set.
- Handles month lengths, leap years and year wrap.
- Accepts a validated load from the set/adjust logic; outputs feed the display decoding stage unchanged in width.

Parameters:
- TICK_DIV, 50000000, system clock cycles per 1 s tick (minimum 2).
- RST_YEAR, 2000, year value loaded at reset (must be 0..9999).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous active-low reset
- run_en  input  1  1 = prescaler counts; 0 = prescaler and time frozen
- load_en  input  1  single-cycle request to load all fields
- load_sec  input  6  0..59
- load_min  input  6  0..59
- load_hour  input  6  0..23
- load_day  input  6  1..days_in_month
- load_month  input  4  1..12
- load_year  input  14  0..9999
- second_out  output  6  current second
- minute_out  output  6  current minute
- hour_out  output  6  current hour
- day_out  output  6  current day of month
- month_out  output  4  current month
- year_out  output  14  current year
- tick_1hz  output  1  one-cycle pulse on every cycle where time advances
- year_wrap  output  1  one-cycle pulse when 9999 rolls to 0000
- load_err  output  1  one-cycle pulse when a load request is rejected

Behaviour:
- Reset (rst_n low at a clk edge):
  - second_out, minute_out, hour_out = 0.
  - day_out = 1, month_out = 1, year_out = RST_YEAR.
  - Prescaler = 0; tick_1hz, year_wrap, load_err = 0.
- Prescaler:
  - When run_en = 1, counts 0..TICK_DIV-1 and wraps.
  - The cycle where the count equals TICK_DIV-1 with run_en = 1 is the advance cycle.
  - Time registers update on that edge; tick_1hz is a registered pulse, high for the cycle after that edge, aligned with the new time value.
- Cascade on advance:
  - second +1; 59 -> 0 carries to minute.
  - minute 59 -> 0 carries to hour; hour 23 -> 0 carries to day.
  - day == days_in_month -> 1 carries to month; month 12 -> 1 carries to year.
  - year 9999 -> 0, with year_wrap pulsed in the same cycle as tick_1hz.
  - All carries resolve on the same edge; there is no multi-cycle ripple.
- days_in_month:
  - 31 for months 1, 3, 5, 7, 8, 10, 12.
  - 30 for months 4, 6, 9, 11.
  - February: 29 if leap, else 28.
  - Leap rule per Optional Feature.
- Load:
  - Sampled on any edge with load_en = 1.
  - Valid when every field is within range, with the day checked against days_in_month(load_month, load_year).
  - Valid load: all registers take load values on that edge and the prescaler clears to 0. The next advance occurs TICK_DIV running cycles later. No tick_1hz pulse is generated.
  - Invalid load: no state change; load_err pulses 1 cycle; the prescaler keeps counting.
- Priority and special cases:
  - Priority order: reset > load > advance.
  - A valid load coinciding with an advance cycle suppresses that advance.
  - run_en = 0 still permits loads.
- Outputs are registered and always hold in-range values; no illegal state is reachable.
- All arithmetic is unsigned at the native port widths; the leap computation may widen internally.

Optional Feature:
- Macro: LEAP_CENTURY_EN.
- Defined: full Gregorian rule. Leap if (year mod 4 == 0 and year mod 100 != 0) or year mod 400 == 0. So 2100 is not leap and 2000 is leap.
- Undefined: leap if year[1:0] == 0. So 2100 is leap.
- Affects both the February rollover and load validation.

Test Plan:
- TICK_DIV = 4, reset, run_en = 1 for 12 cycles -> second_out = 3 after 12 cycles; tick_1hz pulses every 4th cycle; other fields stay 00:00, 01/01/2000.
- Load 23:59:59 31/12/2023, one tick -> 00:00:00 01/01/2024; single tick_1hz; year_wrap = 0.
- Load 23:59:59 28/02/2024, one tick -> 29/02/2024. Repeat with 2023 -> 01/03/2023.
- Load 23:59:59 28/02/2100, one tick:
  - with LEAP_CENTURY_EN -> 01/03/2100;
  - without it -> 29/02/2100.
  - Load 30/02/2024 -> load_err pulse; outputs unchanged.
- Load 23:59:59 31/12/9999, one tick -> 00:00:00 01/01/0000; year_wrap and tick_1hz high in the same cycle.
- Concurrency:
  - Assert load_en (valid, 10:00:00) on an advance cycle -> outputs show 10:00:00 with no tick_1hz; next tick arrives 4 cycles later.
  - run_en = 0 for 20 cycles -> no change.
  - Assert rst_n low mid-count -> reset values on the next edge.

Source files
------------

// File: rtl/calendar_counter.sv
// Calendar counter: 1 s prescaler plus sec/min/hour/day/month/year cascade.
// Define LEAP_CENTURY_EN for the full Gregorian leap rule (default: year%4).
module calendar_counter #(
    parameter int TICK_DIV = 50000000,
    parameter int RST_YEAR = 2000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        run_en,
    input  logic        load_en,
    input  logic [5:0]  load_sec,
    input  logic [5:0]  load_min,
    input  logic [5:0]  load_hour,
    input  logic [5:0]  load_day,
    input  logic [3:0]  load_month,
    input  logic [13:0] load_year,
    output logic [5:0]  second_out,
    output logic [5:0]  minute_out,
    output logic [5:0]  hour_out,
    output logic [5:0]  day_out,
    output logic [3:0]  month_out,
    output logic [13:0] year_out,
    output logic        tick_1hz,
    output logic        year_wrap,
    output logic        load_err
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PS_LAST = PW'(TICK_DIV - 1);

    logic [PW-1:0] presc;
    logic          adv;
    logic          load_ok;

    logic [5:0]    nxt_sec;
    logic [5:0]    nxt_min;
    logic [5:0]    nxt_hour;
    logic [5:0]    nxt_day;
    logic [3:0]    nxt_month;
    logic [13:0]   nxt_year;
    logic          nxt_wrap;

    function automatic logic is_leap(input logic [13:0] y);
        int unsigned yi;
        yi = 32'(y);
`ifdef LEAP_CENTURY_EN
        is_leap = ((yi % 4) == 0 && (yi % 100) != 0) || ((yi % 400) == 0);
`else
        is_leap = (y[1:0] == 2'b00);
`endif
    endfunction

    function automatic logic [5:0] dim(input logic [3:0] m, input logic [13:0] y);
        case (m)
            4'd4, 4'd6, 4'd9, 4'd11: dim = 6'd30;
            4'd2:                    dim = is_leap(y) ? 6'd29 : 6'd28;
            default:                 dim = 6'd31;
        endcase
    endfunction

    assign adv = run_en && (presc == PS_LAST);

    // Range-check every load field; day is checked against the loaded month/year.
    always_comb begin
        load_ok = (load_sec <= 6'd59) && (load_min <= 6'd59)
               && (load_hour <= 6'd23)
               && (load_month >= 4'd1) && (load_month <= 4'd12)
               && (load_year <= 14'd9999)
               && (load_day >= 6'd1)
               && (load_day <= dim(load_month, load_year));
    end

    // Single-edge carry chain from seconds up to the year.
    always_comb begin
        logic c_sec, c_min, c_hour, c_day, c_mon;
        nxt_sec   = second_out;
        nxt_min   = minute_out;
        nxt_hour  = hour_out;
        nxt_day   = day_out;
        nxt_month = month_out;
        nxt_year  = year_out;
        nxt_wrap  = 1'b0;
        c_sec  = (second_out == 6'd59);
        c_min  = c_sec && (minute_out == 6'd59);
        c_hour = c_min && (hour_out == 6'd23);
        c_day  = c_hour && (day_out >= dim(month_out, year_out));
        c_mon  = c_day && (month_out == 4'd12);
        nxt_sec = c_sec ? 6'd0 : second_out + 6'd1;
        if (c_sec) nxt_min = c_min ? 6'd0 : minute_out + 6'd1;
        if (c_min) nxt_hour = c_hour ? 6'd0 : hour_out + 6'd1;
        if (c_hour) nxt_day = c_day ? 6'd1 : day_out + 6'd1;
        if (c_day) nxt_month = c_mon ? 4'd1 : month_out + 4'd1;
        if (c_mon) begin
            nxt_wrap = (year_out == 14'd9999);
            nxt_year = nxt_wrap ? 14'd0 : year_out + 14'd1;
        end
    end

    // State register: reset, then load, then advance.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc      <= '0;
            second_out <= 6'd0;
            minute_out <= 6'd0;
            hour_out   <= 6'd0;
            day_out    <= 6'd1;
            month_out  <= 4'd1;
            year_out   <= 14'(RST_YEAR);
            tick_1hz   <= 1'b0;
            year_wrap  <= 1'b0;
            load_err   <= 1'b0;
        end else begin
            tick_1hz  <= 1'b0;
            year_wrap <= 1'b0;
            load_err  <= 1'b0;
            if (load_en && load_ok) begin
                presc      <= '0;
                second_out <= load_sec;
                minute_out <= load_min;
                hour_out   <= load_hour;
                day_out    <= load_day;
                month_out  <= load_month;
                year_out   <= load_year;
            end else begin
                if (load_en) load_err <= 1'b1;
                if (run_en) presc <= adv ? '0 : presc + PW'(1);
                if (adv) begin
                    second_out <= nxt_sec;
                    minute_out <= nxt_min;
                    hour_out   <= nxt_hour;
                    day_out    <= nxt_day;
                    month_out  <= nxt_month;
                    year_out   <= nxt_year;
                    tick_1hz   <= 1'b1;
                    year_wrap  <= nxt_wrap;
                end
            end
        end
    end

endmodule

// File: tb/tb_calendar_counter.sv
// Testbench for calendar_counter: directed scenarios then random traffic,
// compared every cycle against a seconds-of-day/date reference model.
module tb_calendar_counter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        run_en = 1'b0;
    logic        load_en = 1'b0;
    logic [5:0]  load_sec = '0;
    logic [5:0]  load_min = '0;
    logic [5:0]  load_hour = '0;
    logic [5:0]  load_day = 6'd1;
    logic [3:0]  load_month = 4'd1;
    logic [13:0] load_year = 14'd2000;
    logic [5:0]  second_out;
    logic [5:0]  minute_out;
    logic [5:0]  hour_out;
    logic [5:0]  day_out;
    logic [3:0]  month_out;
    logic [13:0] year_out;
    logic        tick_1hz;
    logic        year_wrap;
    logic        load_err;

    int errors = 0;
    int checks = 0;

    // reference model state
    int m_sod, m_day, m_mon, m_year, m_ph;
    int m_tick, m_wrap, m_err;
    int tick_cnt;

    calendar_counter #(.TICK_DIV(4), .RST_YEAR(2000)) dut (
        .clk(clk), .rst_n(rst_n), .run_en(run_en), .load_en(load_en),
        .load_sec(load_sec), .load_min(load_min), .load_hour(load_hour),
        .load_day(load_day), .load_month(load_month), .load_year(load_year),
        .second_out(second_out), .minute_out(minute_out),
        .hour_out(hour_out), .day_out(day_out), .month_out(month_out),
        .year_out(year_out), .tick_1hz(tick_1hz), .year_wrap(year_wrap),
        .load_err(load_err)
    );

    always #5 clk = ~clk;

    function automatic bit leap(int y);
`ifdef LEAP_CENTURY_EN
        return (y % 4 == 0 && y % 100 != 0) || (y % 400 == 0);
`else
        return (y % 4 == 0);
`endif
    endfunction

    function automatic int mdays(int m, int y);
        int t[12] = '{31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
        if (m < 1 || m > 12) return 0;
        return t[m-1] + ((m == 2 && leap(y)) ? 1 : 0);
    endfunction

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        bit ok;
        m_tick = 0; m_wrap = 0; m_err = 0;
        if (!rst_n) begin
            m_sod = 0; m_day = 1; m_mon = 1; m_year = 2000; m_ph = 0;
            return;
        end
        ok = load_sec <= 59 && load_min <= 59 && load_hour <= 23
          && load_year <= 9999 && load_day >= 1
          && int'(load_day) <= mdays(int'(load_month), int'(load_year));
        if (load_en && ok) begin
            m_sod = load_hour * 3600 + load_min * 60 + load_sec;
            m_day = load_day; m_mon = load_month; m_year = load_year;
            m_ph = 0;
            return;
        end
        if (load_en) m_err = 1;
        if (run_en) begin
            if (m_ph == 3) begin
                m_tick = 1;
                m_sod++;
                if (m_sod == 86400) begin
                    m_sod = 0;
                    m_day++;
                    if (m_day > mdays(m_mon, m_year)) begin
                        m_day = 1;
                        m_mon++;
                        if (m_mon > 12) begin
                            m_mon = 1;
                            m_year++;
                            if (m_year > 9999) begin
                                m_year = 0;
                                m_wrap = 1;
                            end
                        end
                    end
                end
            end
            m_ph = (m_ph + 1) % 4;
        end
    endtask

    task automatic check_all();
        chk("sec", 32'(second_out), m_sod % 60);
        chk("min", 32'(minute_out), (m_sod / 60) % 60);
        chk("hour", 32'(hour_out), m_sod / 3600);
        chk("day", 32'(day_out), m_day);
        chk("month", 32'(month_out), m_mon);
        chk("year", 32'(year_out), m_year);
        chk("tick", 32'(tick_1hz), m_tick);
        chk("wrap", 32'(year_wrap), m_wrap);
        chk("err", 32'(load_err), m_err);
    endtask

    task automatic cyc();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
        if (tick_1hz === 1'b1) tick_cnt++;
    endtask

    task automatic run(int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic do_load(int h, int mi, int s, int d, int mo, int y);
        load_hour = 6'(h); load_min = 6'(mi); load_sec = 6'(s);
        load_day = 6'(d); load_month = 4'(mo); load_year = 14'(y);
        load_en = 1'b1;
        cyc();
        load_en = 1'b0;
    endtask

    task automatic date_is(string tag, int d, int mo, int y);
        chk({tag, "_d"}, 32'(day_out), d);
        chk({tag, "_m"}, 32'(month_out), mo);
        chk({tag, "_y"}, 32'(year_out), y);
    endtask

    initial begin
        int guard;
        tick_cnt = 0;
        m_sod = 0; m_day = 1; m_mon = 1; m_year = 2000; m_ph = 0;

        // reset
        rst_n = 1'b0;
        run(2);
        rst_n = 1'b1;
        date_is("rst", 1, 1, 2000);
        chk("rst_sec", 32'(second_out), 0);

        // free run 12 cycles
        run_en = 1'b1;
        tick_cnt = 0;
        run(12);
        chk("run12_sec", 32'(second_out), 3);
        chk("run12_ticks", tick_cnt, 3);
        date_is("run12", 1, 1, 2000);

        // year rollover to 2024
        do_load(23, 59, 59, 31, 12, 2023);
        tick_cnt = 0;
        run(4);
        date_is("ny", 1, 1, 2024);
        chk("ny_hour", 32'(hour_out), 0);
        chk("ny_ticks", tick_cnt, 1);

        // February leap / non-leap
        do_load(23, 59, 59, 28, 2, 2024);
        run(4);
        date_is("feb24", 29, 2, 2024);
        do_load(23, 59, 59, 28, 2, 2023);
        run(4);
        date_is("feb23", 1, 3, 2023);

        do_load(23, 59, 59, 28, 2, 2100);
        run(4);
`ifdef LEAP_CENTURY_EN
        date_is("feb2100", 1, 3, 2100);
`else
        date_is("feb2100", 29, 2, 2100);
`endif

        // invalid load
        do_load(1, 2, 3, 30, 2, 2024);
        chk("bad_err", 32'(load_err), 1);

        // 9999 wrap
        do_load(23, 59, 59, 31, 12, 9999);
        run(3);
        cyc();
        date_is("wrap", 1, 1, 0);
        chk("wrap_pulse", 32'({tick_1hz, year_wrap}), 3);

        // load on advance cycle suppresses it
        guard = 0;
        while (m_ph != 3 && guard < 8) begin
            cyc();
            guard++;
        end
        chk("sync_guard", 32'(m_ph), 3);
        do_load(10, 0, 0, 5, 6, 2010);
        chk("ldadv_tick", 32'(tick_1hz), 0);
        chk("ldadv_hour", 32'(hour_out), 10);
        tick_cnt = 0;
        run(3);
        chk("ldadv_nt3", tick_cnt, 0);
        cyc();
        chk("ldadv_t4", 32'(tick_1hz), 1);

        // frozen
        run_en = 1'b0;
        run(20);
        chk("frz_sec", 32'(second_out), 1);
        run_en = 1'b1;
        run(2);

        // reset mid-count
        rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        date_is("rst2", 1, 1, 2000);
        chk("rst2_tick", 32'(tick_1hz), 0);

        // random traffic
        for (int i = 0; i < 3000; i++) begin
            int yl[6] = '{1999, 2000, 2023, 2024, 2100, 9999};
            run_en = ($urandom_range(0, 9) != 0);
            rst_n = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 29) == 0) begin
                load_hour = 6'($urandom_range(22, 24));
                load_min = 6'($urandom_range(58, 60));
                load_sec = 6'($urandom_range(50, 60));
                load_day = 6'($urandom_range(0, 31));
                load_month = 4'($urandom_range(0, 13));
                load_year = ($urandom_range(0, 7) == 0)
                    ? 14'($urandom_range(0, 10000))
                    : 14'(yl[$urandom_range(0, 5)]);
                if ($urandom_range(0, 2) != 0) begin
                    load_day = 6'($urandom_range(27, 28));
                    load_hour = 6'd23;
                    load_min = 6'd59;
                    load_sec = 6'd58;
                end
                load_en = 1'b1;
            end
            cyc();
            load_en = 1'b0;
        end
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
